// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer scheduler.
package buzzer_pkg;

  localparam int unsigned NOTE_W    = 5;
  localparam int unsigned SRC_W     = 2;
  localparam int unsigned HOURS_W   = 4;
  localparam int unsigned ALARM_LEN = 16;
  localparam int unsigned PTR_W     = $clog2(ALARM_LEN);

  localparam logic [NOTE_W-1:0]  SILENT      = NOTE_W'(0);
  localparam logic [NOTE_W-1:0]  BEEP_NOTE   = NOTE_W'(15);
  localparam logic [NOTE_W-1:0]  CHIME_NOTE  = NOTE_W'(8);
  localparam logic [HOURS_W-1:0] MAX_STRIKES = HOURS_W'(12);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BEEP       = 3'd1,
    ST_CHIME_TONE = 3'd2,
    ST_CHIME_GAP  = 3'd3,
    ST_ALARM      = 3'd4
  } state_t;

  typedef enum logic [SRC_W-1:0] {
    SRC_NONE  = 2'd0,
    SRC_BEEP  = 2'd1,
    SRC_CHIME = 2'd2,
    SRC_ALARM = 2'd3
  } src_t;

  // Out-of-range strike counts (0 or >12) ring a full twelve.
  function automatic logic [HOURS_W-1:0] norm_strikes(input logic [HOURS_W-1:0] hours);
    return ((hours == '0) || (hours > MAX_STRIKES)) ? MAX_STRIKES : hours;
  endfunction

endpackage

// File: rtl/alarm_rom.sv
// Alarm melody: 4-bit step address to 5-bit note index.
module alarm_rom
  import buzzer_pkg::*;
(
  input  logic [PTR_W-1:0]  addr,
  output logic [NOTE_W-1:0] note
);

  // Combinational melody lookup.
  always_comb begin
    note = SILENT;
    case (addr)
      4'd0:  note = 5'd13;
      4'd1:  note = 5'd15;
      4'd2:  note = 5'd17;
      4'd3:  note = 5'd18;
      4'd4:  note = 5'd17;
      4'd5:  note = 5'd15;
      4'd6:  note = 5'd13;
      4'd7:  note = 5'd10;
      4'd8:  note = 5'd13;
      4'd9:  note = 5'd15;
      4'd10: note = 5'd17;
      4'd11: note = 5'd20;
      4'd12: note = 5'd21;
      4'd13: note = 5'd20;
      4'd14: note = 5'd17;
      4'd15: note = 5'd15;
      default: note = SILENT;
    endcase
  end

endmodule

// File: rtl/buzzer_scheduler.sv
// Arbitrates key beep, hourly chime and alarm onto one tone generator, stepped by a 4 Hz tick.
module buzzer_scheduler
  import buzzer_pkg::*;
(
  input  logic               sys_CLK,
  input  logic               rst,
  input  logic               tick_4hz,
  input  logic               key_beep,
  input  logic               chime_req,
  input  logic [HOURS_W-1:0] chime_hours,
  input  logic               alarm_on,
  input  logic               stop,
  output logic [NOTE_W-1:0]  note_idx,
  output logic               busy,
  output logic [SRC_W-1:0]   active_src
);

  state_t              state_q, state_d;
  src_t                src_q, src_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                busy_q, busy_d;
  logic                beep_pend_q, beep_pend_d;
  logic                chime_pend_q, chime_pend_d;
  logic [HOURS_W-1:0]  pend_hours_q, pend_hours_d;
  logic [HOURS_W-1:0]  strikes_q, strikes_d;
  logic                phase_q, phase_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                snooze_q, snooze_d;

  logic [PTR_W-1:0]    rom_addr;
  logic [NOTE_W-1:0]   rom_note;
  logic                snooze_eff;
  logic                alarm_go;
  logic                pick;

  // Next melody step: restart at 0 on entry, otherwise advance with 4-bit wrap.
  assign rom_addr = (state_q == ST_ALARM) ? PTR_W'(ptr_q + 1'b1) : '0;

  alarm_rom u_alarm_rom (
    .addr (rom_addr),
    .note (rom_note)
  );

  // State, request latches and registered outputs.
  always_ff @(posedge sys_CLK) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_NONE;
      note_q       <= SILENT;
      busy_q       <= 1'b0;
      beep_pend_q  <= 1'b0;
      chime_pend_q <= 1'b0;
      pend_hours_q <= '0;
      strikes_q    <= '0;
      phase_q      <= 1'b0;
      ptr_q        <= '0;
      snooze_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      note_q       <= note_d;
      busy_q       <= busy_d;
      beep_pend_q  <= beep_pend_d;
      chime_pend_q <= chime_pend_d;
      pend_hours_q <= pend_hours_d;
      strikes_q    <= strikes_d;
      phase_q      <= phase_d;
      ptr_q        <= ptr_d;
      snooze_q     <= snooze_d;
    end
  end

  // Request capture every cycle; arbitration and sequencing only on ticks.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    note_d       = note_q;
    beep_pend_d  = beep_pend_q;
    chime_pend_d = chime_pend_q;
    pend_hours_d = pend_hours_q;
    strikes_d    = strikes_q;
    phase_d      = phase_q;
    ptr_d        = ptr_q;
    pick         = 1'b0;

    snooze_eff = snooze_q | (stop & (state_q == ST_ALARM));
    alarm_go   = alarm_on & ~snooze_eff;
    snooze_d   = alarm_on & snooze_eff;

    if (chime_req) begin
      chime_pend_d = 1'b1;
      pend_hours_d = norm_strikes(chime_hours);
    end
    if (key_beep && (state_q != ST_ALARM)) begin
      beep_pend_d = 1'b1;
    end

    if (tick_4hz) begin
      if (alarm_go) begin
        state_d     = ST_ALARM;
        src_d       = SRC_ALARM;
        note_d      = rom_note;
        ptr_d       = rom_addr;
        phase_d     = 1'b0;
        beep_pend_d = 1'b0;
      end else begin
        case (state_q)
          ST_CHIME_TONE: begin
            if (phase_q) begin
              state_d = ST_CHIME_GAP;
              note_d  = SILENT;
              phase_d = 1'b0;
            end else begin
              phase_d = 1'b1;
            end
          end
          ST_CHIME_GAP: begin
            if (phase_q) begin
              phase_d   = 1'b0;
              strikes_d = HOURS_W'(strikes_q - 1'b1);
              if (strikes_q <= HOURS_W'(1)) begin
                pick = 1'b1;
              end else begin
                state_d = ST_CHIME_TONE;
                note_d  = CHIME_NOTE;
              end
            end else begin
              phase_d = 1'b1;
            end
          end
          ST_ALARM: begin
            state_d = ST_IDLE;
            src_d   = SRC_NONE;
            note_d  = SILENT;
            ptr_d   = '0;
          end
          default: pick = 1'b1;
        endcase

        if (pick) begin
          if (chime_pend_d) begin
            state_d      = ST_CHIME_TONE;
            src_d        = SRC_CHIME;
            note_d       = CHIME_NOTE;
            strikes_d    = pend_hours_d;
            chime_pend_d = 1'b0;
            phase_d      = 1'b0;
          end else if (beep_pend_d) begin
            state_d     = ST_BEEP;
            src_d       = SRC_BEEP;
            note_d      = BEEP_NOTE;
            beep_pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            src_d   = SRC_NONE;
            note_d  = SILENT;
          end
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign note_idx   = note_q;
  assign busy       = busy_q;
  assign active_src = src_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed and randomized checks of buzzer_scheduler against a tick-level behavioural model.
module tb_buzzer_scheduler;

  logic       sys_CLK = 1'b0;
  logic       rst = 1'b1;
  logic       tick_4hz = 1'b0;
  logic       key_beep = 1'b0;
  logic       chime_req = 1'b0;
  logic [3:0] chime_hours = 4'd0;
  logic       alarm_on = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] note_idx;
  logic       busy;
  logic [1:0] active_src;

  int checks = 0;
  int failures = 0;

  // Melody the alarm is expected to play, step 0..15.
  int melody [16] = '{13, 15, 17, 18, 17, 15, 13, 10, 13, 15, 17, 20, 21, 20, 17, 15};

  // Model: which source plays, ticks elapsed in it, strikes of the current chime, pending requests.
  int m_src = 0;
  int m_el = 0;
  int m_strikes = 0;
  bit m_cpend = 0;
  int m_chours = 0;
  bit m_bpend = 0;
  bit m_snooze = 0;

  buzzer_scheduler dut (
    .sys_CLK     (sys_CLK),
    .rst         (rst),
    .tick_4hz    (tick_4hz),
    .key_beep    (key_beep),
    .chime_req   (chime_req),
    .chime_hours (chime_hours),
    .alarm_on    (alarm_on),
    .stop        (stop),
    .note_idx    (note_idx),
    .busy        (busy),
    .active_src  (active_src)
  );

  always #5 sys_CLK = ~sys_CLK;

  function automatic int strikes_of(input int h);
    return (h == 0 || h > 12) ? 12 : h;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit snz, go, cp, bp, done;
    int ch;
    if (rst) begin
      m_src = 0; m_el = 0; m_strikes = 0; m_cpend = 0; m_chours = 0;
      m_bpend = 0; m_snooze = 0;
      return;
    end
    snz = m_snooze || (stop && m_src == 3);
    go  = alarm_on && !snz;
    cp  = m_cpend || chime_req;
    ch  = chime_req ? strikes_of(int'(chime_hours)) : m_chours;
    bp  = m_bpend || (key_beep && m_src != 3);
    if (tick_4hz) begin
      if (go) begin
        if (m_src == 3) m_el++;
        else begin m_src = 3; m_el = 0; end
        bp = 0;
      end else if (m_src == 3) begin
        m_src = 0;
      end else begin
        done = 0;
        if (m_src == 2) begin
          m_el++;
          if (m_el == 4 * m_strikes) done = 1;
        end else begin
          done = 1;
        end
        if (done) begin
          if (cp) begin m_src = 2; m_strikes = ch; m_el = 0; cp = 0; end
          else if (bp) begin m_src = 1; bp = 0; end
          else m_src = 0;
        end
      end
    end
    m_cpend  = cp;
    m_chours = ch;
    m_bpend  = bp;
    m_snooze = alarm_on && snz;
  endtask

  function automatic int exp_note();
    case (m_src)
      1: return 15;
      2: return ((m_el % 4) < 2) ? 8 : 0;
      3: return melody[m_el % 16];
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag);
    logic [4:0] en;
    logic [1:0] es;
    logic       eb;
    en = 5'(exp_note());
    es = 2'(m_src);
    eb = (m_src != 0);
    checks++;
    assert (note_idx === en) else begin
      failures++;
      $error("FAIL %s note_idx got=%0d exp=%0d t=%0t", tag, note_idx, en, $time);
    end
    checks++;
    assert (active_src === es) else begin
      failures++;
      $error("FAIL %s active_src got=%0d exp=%0d t=%0t", tag, active_src, es, $time);
    end
    checks++;
    assert (busy === eb) else begin
      failures++;
      $error("FAIL %s busy got=%0d exp=%0d t=%0t", tag, busy, eb, $time);
    end
  endtask

  // One clock with the given tick and pulses; levels (rst, alarm_on) are set by the caller.
  task automatic step(input string tag, input logic t, input logic kb, input logic cr,
                      input logic [3:0] hrs, input logic st);
    @(negedge sys_CLK);
    tick_4hz = t; key_beep = kb; chime_req = cr; chime_hours = hrs; stop = st;
    @(posedge sys_CLK);
    model_step();
    #1;
    check(tag);
  endtask

  // One tick period: tick cycle carrying the pulses, then two quiet cycles.
  task automatic period(input string tag, input logic kb, input logic cr,
                        input logic [3:0] hrs, input logic st);
    step(tag, 1'b1, kb, cr, hrs, st);
    step(tag, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(tag, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) period(tag, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    // Reset state, including a tick during reset.
    rst = 1'b1;
    step("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step("reset_tick", 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    rst = 1'b0;
    quiet("idle", 2);

    // Key beep latched between ticks plays for one tick.
    step("beep_req", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    quiet("beep", 3);

    // Three strikes, then a zero count ringing twelve.
    step("chime3_req", 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    quiet("chime3", 14);
    period("chime0", 1'b0, 1'b1, 4'd0, 1'b0);
    quiet("chime0", 50);

    // Out-of-range count and a re-request while pending re-samples the count.
    step("chime_re1", 1'b0, 1'b0, 1'b1, 4'd14, 1'b0);
    step("chime_re2", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    quiet("chime_re", 10);

    // Alarm preempts strike 2 of a chime; chime does not resume.
    period("pre_chime", 1'b0, 1'b1, 4'd4, 1'b0);
    quiet("pre_chime", 5);
    alarm_on = 1'b1;
    step("pre_beep", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    quiet("preempt", 3);
    alarm_on = 1'b0;
    quiet("post_preempt", 4);

    // Alarm for 20 ticks, stop on the 21st tick, no re-entry while still on.
    alarm_on = 1'b1;
    quiet("alarm20", 20);
    period("stop", 1'b1, 1'b0, 4'd0, 1'b1);
    quiet("snoozed", 4);
    alarm_on = 1'b0;
    quiet("alarm_off", 2);
    alarm_on = 1'b1;
    quiet("re_alarm", 3);
    alarm_on = 1'b0;
    quiet("alarm_fall", 2);

    // Stop outside alarm is ignored.
    period("stray_stop", 1'b0, 1'b0, 4'd0, 1'b1);
    alarm_on = 1'b1;
    quiet("alarm_after_stop", 2);
    alarm_on = 1'b0;
    quiet("alarm_after_stop", 2);

    // Beep and chime in the same tick cycle: chime first, then beep.
    period("both", 1'b1, 1'b1, 4'd2, 1'b0);
    quiet("both", 11);

    // Chime queued during a chime plays after it.
    period("chime_q", 1'b0, 1'b1, 4'd1, 1'b0);
    period("chime_q2", 1'b0, 1'b1, 4'd2, 1'b0);
    quiet("chime_q", 14);

    // Reset mid-alarm without a tick drops everything.
    alarm_on = 1'b1;
    quiet("rst_alarm", 3);
    step("rst_pend", 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    rst = 1'b1;
    step("rst_mid", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    alarm_on = 1'b0;
    quiet("after_rst", 4);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) alarm_on = ~alarm_on;
      rst = ($urandom_range(0, 499) == 0);
      step("rand", ($urandom_range(0, 2) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 79) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 39) == 0));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
